// File: rtl/qe_ctl_if.sv
// Host/pin-side signal bundle for the quadrature encoder controller.
// The master drives pins and host requests; the slave (qe_ctl) returns the snapshot and status.
interface qe_ctl_if #(
  parameter int unsigned W = 8
);
  logic         i;
  logic         q;
  logic         en;
  logic         zero;
  logic         req;
  logic         errclr;
  logic         ack;
  logic [W-1:0] pos;
  logic         dir;
  logic         err;

  modport master (
    output i, q, en, zero, req, errclr,
    input  ack, pos, dir, err
  );

  modport slave (
    input  i, q, en, zero, req, errclr,
    output ack, pos, dir, err
  );
endinterface

// File: rtl/qe_ctl.sv
// Quadrature encoder front end: sync + glitch filter, Gray step decoder,
// wrapping position counter and a 4-phase req/ack snapshot port.
module qe_ctl #(
  parameter int unsigned W    = 8,
  parameter int unsigned FILT = 3
) (
  input  logic     clk,
  input  logic     clr,
  qe_ctl_if.slave  bus
);

  localparam int unsigned CW = (FILT > 1) ? $clog2(FILT) : 1;

  typedef enum logic [1:0] {
    S00 = 2'b00,
    S01 = 2'b01,
    S10 = 2'b10,
    S11 = 2'b11
  } phase_t;

  logic [1:0]    sync1;
  logic [1:0]    s;
  logic [CW-1:0] fcnt;
  phase_t        acc;
  phase_t        up_nxt;
  phase_t        dn_nxt;
  logic          init;
  logic [W-1:0]  count;
  logic          accept;

  // Neighbours of the accepted phase in the up (i leads q) direction and its reverse.
  always_comb begin
    up_nxt = S00;
    dn_nxt = S00;
    case (acc)
      S00: begin up_nxt = S10; dn_nxt = S01; end
      S10: begin up_nxt = S11; dn_nxt = S00; end
      S11: begin up_nxt = S01; dn_nxt = S10; end
      S01: begin up_nxt = S00; dn_nxt = S11; end
      default: begin up_nxt = S00; dn_nxt = S00; end
    endcase
  end

  // s has been stable and different from acc for FILT full cycles.
  assign accept = (s != acc) && (fcnt == CW'(FILT - 1));

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      sync1   <= '0;
      s       <= '0;
      fcnt    <= '0;
      acc     <= S00;
      init    <= 1'b1;
      count   <= '0;
      bus.ack <= 1'b0;
      bus.pos <= '0;
      bus.dir <= 1'b0;
      bus.err <= 1'b0;
    end else begin
      sync1 <= {bus.i, bus.q};
      s     <= sync1;

      if (s == acc || accept || sync1 != s) fcnt <= '0;
      else                                  fcnt <= fcnt + CW'(1);

      if (bus.errclr) bus.err <= 1'b0;

      if (accept) begin
        acc <= phase_t'(s);
        if (init) begin
          init <= 1'b0;
        end else if (s == up_nxt) begin
          if (bus.en && !bus.zero) begin
            count   <= count + W'(1);
            bus.dir <= 1'b1;
          end
        end else if (s == dn_nxt) begin
          if (bus.en && !bus.zero) begin
            count   <= count - W'(1);
            bus.dir <= 1'b0;
          end
        end else begin
          bus.err <= 1'b1;
        end
      end

      // Clear overrides any step counted on the same edge.
      if (bus.zero) count <= '0;

      // Snapshot captures the count as it stood before this edge.
      if (bus.req && !bus.ack) begin
        bus.pos <= count;
        bus.ack <= 1'b1;
      end else if (!bus.req && bus.ack) begin
        bus.ack <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_qe_ctl.sv
// Bench for qe_ctl: directed scenarios plus randomized pin/host activity,
// checked every cycle against a run-length/phase-order reference model.
module tb_qe_ctl;

  localparam int unsigned W    = 8;
  localparam int unsigned FILT = 3;
  localparam int          MOD  = 1 << W;

  logic clk = 1'b0;
  logic clr;
  always #5 clk = ~clk;

  qe_ctl_if #(.W(W)) bus ();
  qe_ctl #(.W(W), .FILT(FILT)) dut (.clk(clk), .clr(clr), .bus(bus));

  int n_chk  = 0;
  int n_pass = 0;

  // Reference model state
  int       m_cnt, m_pos;
  bit       m_dir, m_err, m_ack, m_init;
  bit [1:0] m_acc;
  bit [1:0] pin_hist[$];
  bit [1:0] s_hist[$];
  bit [1:0] cur;

  task automatic chk(input string tag, input int act, input int exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d at %0t", tag, act, exp, $time);
  endtask

  // Position of a phase pair along the up sequence 00,10,11,01.
  function automatic int ord(input bit [1:0] v);
    case (v)
      2'b00:   return 0;
      2'b10:   return 1;
      2'b11:   return 2;
      default: return 3;
    endcase
  endfunction

  function automatic bit [1:0] up_of(input bit [1:0] v);
    case (v)
      2'b00:   return 2'b10;
      2'b10:   return 2'b11;
      2'b11:   return 2'b01;
      default: return 2'b00;
    endcase
  endfunction

  function automatic bit [1:0] dn_of(input bit [1:0] v);
    case (v)
      2'b00:   return 2'b01;
      2'b01:   return 2'b11;
      2'b11:   return 2'b10;
      default: return 2'b00;
    endcase
  endfunction

  task automatic model_reset();
    m_cnt = 0; m_pos = 0; m_dir = 0; m_err = 0; m_ack = 0; m_init = 1;
    m_acc = 2'b00;
    pin_hist.delete(); pin_hist.push_back(2'b00); pin_hist.push_back(2'b00);
    s_hist.delete();
  endtask

  task automatic model_step();
    bit [1:0] s_now;
    bit       run_ok, illegal;
    int       d;
    s_now = pin_hist.pop_front();
    pin_hist.push_back({bus.i, bus.q});
    s_hist.push_back(s_now);
    if (s_hist.size() > FILT) void'(s_hist.pop_front());

    if (bus.req && !m_ack) begin
      m_pos = m_cnt;
      m_ack = 1;
    end else if (!bus.req && m_ack) begin
      m_ack = 0;
    end

    run_ok = (s_hist.size() == FILT);
    foreach (s_hist[k]) if (s_hist[k] != s_now) run_ok = 0;
    illegal = 0;
    if (run_ok && s_now != m_acc) begin
      if (m_init) begin
        m_init = 0;
      end else begin
        d = (ord(s_now) - ord(m_acc) + 4) % 4;
        if (d == 2) illegal = 1;
        else if (bus.en && !bus.zero) begin
          m_cnt = (d == 1) ? (m_cnt + 1) % MOD : (m_cnt + MOD - 1) % MOD;
          m_dir = (d == 1);
        end
      end
      m_acc = s_now;
    end
    if (bus.zero)   m_cnt = 0;
    if (bus.errclr) m_err = 0;
    if (illegal)    m_err = 1;
  endtask

  // One clock: model follows the edge, outputs compared on the falling edge.
  task automatic cyc();
    @(posedge clk);
    if (clr) model_reset();
    else     model_step();
    @(negedge clk);
    chk("ack", int'(bus.ack), int'(m_ack));
    chk("pos", int'(bus.pos), m_pos);
    chk("dir", int'(bus.dir), int'(m_dir));
    chk("err", int'(bus.err), int'(m_err));
  endtask

  task automatic hold(input int n);
    repeat (n) cyc();
  endtask

  task automatic set_pins(input bit [1:0] v, input int n);
    cur = v;
    {bus.i, bus.q} = v;
    hold(n);
  endtask

  task automatic snap(input string tag, input int exp_pos);
    bus.req = 1'b1;
    cyc();
    chk({tag, "_ack"}, int'(bus.ack), 1);
    chk({tag, "_pos"}, int'(bus.pos), exp_pos);
    bus.req = 1'b0;
    cyc();
    chk({tag, "_drop"}, int'(bus.ack), 0);
  endtask

  initial begin
    model_reset();
    clr = 1'b1;
    {bus.i, bus.q} = 2'b11; cur = 2'b11;
    bus.en = 1'b1; bus.zero = 1'b0; bus.req = 1'b0; bus.errclr = 1'b0;
    hold(2);
    clr = 1'b0;
    hold(10);
    chk("rst_err", int'(bus.err), 0);
    snap("rst", 0);

    // Four clean up steps from S11
    repeat (4) set_pins(up_of(cur), 6);
    snap("up4", 4);
    chk("up4_dir", int'(bus.dir), 1);

    // Wrap below zero and back
    bus.zero = 1'b1; cyc(); bus.zero = 1'b0;
    snap("zero", 0);
    set_pins(dn_of(cur), 6);
    snap("wrap_dn", 255);
    chk("wrap_dir", int'(bus.dir), 0);
    set_pins(up_of(cur), 6);
    snap("wrap_up", 0);

    // Short pulse on i is rejected; a FILT-long pulse is accepted then undone
    set_pins(cur ^ 2'b10, 2);
    set_pins(cur ^ 2'b10, 6);
    snap("glitch", 0);
    chk("glitch_err", int'(bus.err), 0);
    set_pins(cur ^ 2'b10, 3);
    {bus.i, bus.q} = cur ^ 2'b10; cur = cur ^ 2'b10;
    hold(2);
    snap("pulse3_mid", 1);
    hold(6);
    snap("pulse3_end", 0);

    // Illegal double transition, errclr priority, count enable
    repeat (2) set_pins(up_of(cur), 6);
    set_pins(2'b11, 6);
    chk("ill_err", int'(bus.err), 1);
    snap("ill", 2);
    {bus.i, bus.q} = 2'b00; cur = 2'b00;
    hold(4);
    bus.errclr = 1'b1; cyc(); bus.errclr = 1'b0;
    chk("errclr_prio", int'(bus.err), 1);
    hold(3);
    bus.errclr = 1'b1; cyc(); bus.errclr = 1'b0;
    chk("errclr", int'(bus.err), 0);
    bus.en = 1'b0;
    repeat (2) set_pins(up_of(cur), 6);
    bus.en = 1'b1;
    snap("en_off", 2);

    // zero on the accepting edge of an up step
    {bus.i, bus.q} = up_of(cur); cur = up_of(cur);
    hold(4);
    bus.zero = 1'b1; cyc(); bus.zero = 1'b0;
    hold(3);
    snap("zero_step", 0);

    // req held while stepping: one capture only
    bus.req = 1'b1;
    cyc();
    repeat (4) set_pins(up_of(cur), 5);
    chk("hold_pos", int'(bus.pos), 0);
    bus.req = 1'b0;
    hold(2);
    snap("recap", 4);

    // clr aborts a handshake asynchronously
    bus.req = 1'b1;
    cyc();
    clr = 1'b1;
    #1;
    chk("clr_abort", int'(bus.ack), 0);
    bus.req = 1'b0;
    hold(2);
    clr = 1'b0;
    hold(8);
    snap("clr_pos", 0);

    // Randomized pins and host activity
    for (int n = 0; n < 3000; ) begin
      int h;
      bit [1:0] nxt;
      h = $urandom_range(1, 7);
      case ($urandom_range(0, 9))
        0, 1, 2, 3: nxt = up_of(cur);
        4, 5, 6:    nxt = dn_of(cur);
        default:    nxt = 2'($urandom_range(0, 3));
      endcase
      {bus.i, bus.q} = nxt; cur = nxt;
      for (int j = 0; j < h; j++) begin
        bus.en     = ($urandom_range(0, 9) != 0);
        bus.zero   = ($urandom_range(0, 29) == 0);
        bus.errclr = ($urandom_range(0, 19) == 0);
        if ($urandom_range(0, 3) == 0) bus.req = ~bus.req;
        clr = ($urandom_range(0, 599) == 0);
        cyc();
        n++;
      end
    end
    clr = 1'b0; bus.zero = 1'b0; bus.errclr = 1'b0; bus.req = 1'b0;
    hold(4);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/qe_ctl.md
# qe_ctl

Quadrature encoder front-end controller: synchronizes and glitch-filters raw `i`/`q` phase inputs, sequences them through a 4-state Gray decoder, and maintains a wrapping up/down position count. A 4-phase `req`/`ack` handshake gives the host a stable position snapshot, and a sticky `err` flag reports illegal double transitions. It sits between the encoder pins and the host register interface, in front of the counting datapath.

## Interface
- `W`, default 8: position counter and snapshot width.
- `FILT`, default 3: consecutive cycles a new phase pair must hold before it is accepted. Legal range is ≥1.
- `clk` in 1: single clock. All state changes occur on its rising edge.
- `clr` in 1: reset, asynchronous and active-high. It clears every register.
- `i` in 1: raw phase A, asynchronous to `clk`.
- `q` in 1: raw phase B, asynchronous to `clk`.
- `en` in 1: count enable. At 0, decoding continues but the count is frozen.
- `zero` in 1: synchronous clear of the position count.
- `req` in 1: snapshot request, level-sensitive, 4-phase.
- `ack` out 1: snapshot acknowledge.
- `pos` out W: last snapshot of the position count.
- `dir` out 1: direction of the last counted step (1 = up).
- `err` out 1: sticky illegal-transition flag.
- `errclr` in 1: clears `err`.

## Operation
- **Reset values:** `ack`=0, `pos`=0, `dir`=0, `err`=0. Internal count, both synchronizers, filter counter and accepted state `acc` are all 0. An internal `init` flag is 1.
- **Synchronizer:** each of `i` and `q` passes through 2 flops, giving `s`={si,sq}.
- **Filter:** a counter increments each cycle that `s`≠`acc` with `s` unchanged from the previous cycle. It reloads to 0 whenever `s` changes or `s`==`acc`. When it reaches FILT, `s` is accepted.
- **Decoder:** states are {i,q} = S00, S10, S11, S01.
  - The step S00→S10→S11→S01→S00 is up, i.e. `i` leads `q`.
  - The reverse order is down.
  - A change of both bits in one accept is illegal: `err`←1, count unchanged, `acc`←new value.
- **First accept after reset** (`init`=1): only loads `acc`, then clears `init`. There is no count and no `err`.
- **Count update:** each legal step does count ± 1, wrapping modulo 2^W. Examples for W=8: 255+1 = 0 and 0−1 = 255. Each counted step also sets `dir`.
- **`en`=0:** `acc` still tracks the input. The count and `dir` do not change, and illegal steps still set `err`.
- **`zero`=1:** count←0. This has priority over a simultaneous step, which is discarded; `acc` still updates.
- **Snapshot handshake:**
  - With `req`=1 and `ack`=0: `pos`←count as it stands before this edge's update, and `ack`←1.
  - With `req`=0 and `ack`=1: `ack`←0.
  - `pos` is stable while `ack`=1. Exactly one capture is made per handshake.
- **`errclr`:** clears `err`. A simultaneous illegal step wins, and `err` stays 1.
- **`clr` mid-operation:** aborts any handshake (`ack`=0) and restarts with `init`=1.

## Timing
- **Pin to count:** a pin change settled before edge k is in `s` after edge k+1. The count, `acc` and `dir` update at edge k+1+FILT. With FILT=3 this is 4 edges.
- **Glitch rejection:** a pulse on `s` shorter than FILT cycles is never accepted.
- **Snapshot:** `ack` and `pos` are valid 1 edge after `req` is seen high. `ack` drops 1 edge after `req` is seen low.
- **Error flag:** `err` asserts on the same edge as the offending accept.
- **Outputs:** all outputs are registered, with no combinational path from any input.

## Test plan
- **Reset release:** `clr` pulse with i=q=1, held 10 cycles. Required: `acc`=S11, count 0, `err`=0.
- **Up count:** 4 clean up steps (00→10→11→01→00), each held 6 cycles, then `req`. Required: `pos`=4, `dir`=1, `ack` 1 edge after `req`.
- **Wrap:** 1 down step from 0, W=8. Required: snapshot `pos`=255, `dir`=0. Then 1 up step gives `pos`=0.
- **Glitch rejection:** a 2-cycle pulse on `i` at FILT=3. Required: count unchanged and `err`=0. The same pulse held 3 cycles must count exactly once.
- **Illegal and enable:** 00→11 direct. Required: `err`=1 and count unchanged. Then `errclr` asserted together with another illegal step leaves `err`=1. Then 2 up steps with `en`=0 leave count unchanged.
- **Priority and handshake:**
  - `zero` on the same edge as an up step gives count 0.
  - Holding `req`=1 for 20 cycles while stepping up gives a single capture, with `pos` unchanged until `req` falls and rises again.
